// File: rtl/zero_flag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : zero_flag_pipe
// Description : Pipelined zero/negative detector built as a registered OR tree,
//               with architectural Z/N flags updated by flag-setting results.
// Revision    : 1.0  initial release
// ============================================================================
module zero_flag_pipe #(
    parameter int WIDTH = 64,
    parameter int FANIN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_set_flags,
    input  logic             flush,
    output logic             out_valid,
    output logic             out_zero,
    output logic             out_neg,
    output logic             flag_z,
    output logic             flag_n
);

    function automatic int f_levels();
        int w;
        int n;
        w = WIDTH;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (w > 1) begin
                w = (w + FANIN - 1) / FANIN;
                n = n + 1;
            end
        end
        return (n < 1) ? 1 : n;
    endfunction

    function automatic int f_lvl_width(input int lvl);
        int w;
        w = WIDTH;
        for (int i = 0; i < lvl; i++) begin
            w = (w + FANIN - 1) / FANIN;
        end
        return w;
    endfunction

    function automatic int f_lvl_off(input int lvl);
        int off;
        off = 0;
        for (int m = 1; m < lvl; m++) begin
            off = off + f_lvl_width(m);
        end
        return off;
    endfunction

    localparam int c_LEVELS = f_levels();
    localparam int c_TOT    = f_lvl_off(c_LEVELS + 1);

    logic [c_TOT-1:0]    w_tree;
    logic [c_LEVELS:1]   w_vin;
    logic [c_LEVELS:1]   w_sin;
    logic [c_LEVELS:1]   w_fin;
    logic [c_LEVELS:1]   w_adv;
    logic [c_LEVELS:1]   r_vld;
    logic [c_LEVELS:1]   r_sign;
    logic [c_LEVELS:1]   r_set;
    logic                r_flag_z;
    logic                r_flag_n;

    always_comb begin
        w_vin    = '0;
        w_sin    = '0;
        w_fin    = '0;
        w_vin[1] = in_valid;
        w_sin[1] = in_data[WIDTH-1];
        w_fin[1] = in_set_flags;
        for (int l = 2; l <= c_LEVELS; l++) begin
            w_vin[l] = r_vld[l-1];
            w_sin[l] = r_sign[l-1];
            w_fin[l] = r_set[l-1];
        end
        w_adv = flush ? '0 : w_vin;
    end

    for (genvar l = 1; l <= c_LEVELS; l++) begin : g_lvl
        localparam int c_NI = f_lvl_width(l - 1);
        localparam int c_NO = f_lvl_width(l);
        localparam int c_OO = f_lvl_off(l);

        logic [c_NI-1:0]       w_src;
        logic [c_NO*FANIN-1:0] w_pad;
        logic [c_NO-1:0]       w_or;
        logic [c_NO-1:0]       r_vec;

        if (l == 1) begin : g_first
            assign w_src = in_data;
        end else begin : g_next
            assign w_src = w_tree[f_lvl_off(l - 1) +: c_NI];
        end

        always_comb begin
            w_pad            = '0;
            w_pad[c_NI-1:0]  = w_src;
            w_or             = '0;
            for (int j = 0; j < c_NO; j++) begin
                w_or[j] = |w_pad[j*FANIN +: FANIN];
            end
        end

        // The last stage stores the zero indication itself, so reset yields out_zero = 0.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_vec <= '0;
            end else if (w_adv[l]) begin
                r_vec <= (l == c_LEVELS) ? ~w_or : w_or;
            end
        end

        assign w_tree[c_OO +: c_NO] = r_vec;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld    <= '0;
            r_sign   <= '0;
            r_set    <= '0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
        end else begin
            r_vld <= w_adv;
            for (int l = 1; l <= c_LEVELS; l++) begin
                if (w_adv[l]) begin
                    r_sign[l] <= w_sin[l];
                    r_set[l]  <= w_fin[l];
                end
            end
            if (!flush && r_vld[c_LEVELS] && r_set[c_LEVELS]) begin
                r_flag_z <= w_tree[c_TOT-1];
                r_flag_n <= r_sign[c_LEVELS];
            end
        end
    end

    assign out_valid = r_vld[c_LEVELS];
    assign out_zero  = w_tree[c_TOT-1];
    assign out_neg   = r_sign[c_LEVELS];
    assign flag_z    = r_flag_z;
    assign flag_n    = r_flag_n;

endmodule
`default_nettype wire

// File: tb/tb_zero_flag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_zero_flag_pipe
// Description : Self-checking bench for zero_flag_pipe at 64/4, 50/3 and 1-bit.
// Revision    : 1.0  initial release
// ============================================================================
module tb_zero_flag_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_set_flags;
    logic        flush;
    logic [63:0] data_a;
    logic [49:0] data_b;
    logic [0:0]  data_c;
    logic [2:0]  ov, oz, on, fz, fn;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    // Expected results scheduled by the edge at which they become visible.
    bit mv[3][8], mz[3][8], mn[3][8], ms[3][8];
    bit dv[3], dz[3], dn[3], ds[3];
    bit efz[3], efn[3];
    int lat[3] = '{3, 4, 1};

    zero_flag_pipe #(.WIDTH(64), .FANIN(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(data_a),
        .in_set_flags(in_set_flags), .flush(flush), .out_valid(ov[0]),
        .out_zero(oz[0]), .out_neg(on[0]), .flag_z(fz[0]), .flag_n(fn[0]));

    zero_flag_pipe #(.WIDTH(50), .FANIN(3)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(data_b),
        .in_set_flags(in_set_flags), .flush(flush), .out_valid(ov[1]),
        .out_zero(oz[1]), .out_neg(on[1]), .flag_z(fz[1]), .flag_n(fn[1]));

    zero_flag_pipe #(.WIDTH(1), .FANIN(4)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(data_c),
        .in_set_flags(in_set_flags), .flush(flush), .out_valid(ov[2]),
        .out_zero(oz[2]), .out_neg(on[2]), .flag_z(fz[2]), .flag_n(fn[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s dut%0d cyc%0d: observed %b expected %b", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 8; j++) mv[k][j] = 1'b0;
            dv[k] = 0; dz[k] = 0; dn[k] = 0; ds[k] = 0;
            efz[k] = 0; efn[k] = 0;
        end
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", k, ov[k], 1'b0);
            chk("rst_zero",  k, oz[k], 1'b0);
            chk("rst_neg",   k, on[k], 1'b0);
            chk("rst_flagz", k, fz[k], 1'b0);
            chk("rst_flagn", k, fn[k], 1'b0);
        end
    endtask

    task automatic step(input bit v, input logic [63:0] d, input bit s, input bit f);
        in_valid     = v;
        in_set_flags = s;
        flush        = f;
        data_a       = d;
        data_b       = d[49:0];
        data_c       = d[0:0];
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 3; k++) begin
            bit z;
            bit n;
            int slot;
            case (k)
                0:       begin z = (d == 64'd0);       n = d[63]; end
                1:       begin z = (d[49:0] == 50'd0); n = d[49]; end
                default: begin z = (d[0] == 1'b0);     n = d[0];  end
            endcase
            if (!f && dv[k] && ds[k]) begin
                efz[k] = dz[k];
                efn[k] = dn[k];
            end
            if (f) begin
                for (int j = 0; j < 8; j++) mv[k][j] = 1'b0;
                dv[k] = 0;
            end else begin
                if (v) begin
                    slot = (cyc + lat[k] - 1) % 8;
                    mv[k][slot] = 1; mz[k][slot] = z; mn[k][slot] = n; ms[k][slot] = s;
                end
                slot  = cyc % 8;
                dv[k] = mv[k][slot];
                dz[k] = mz[k][slot];
                dn[k] = mn[k][slot];
                ds[k] = ms[k][slot];
                mv[k][slot] = 0;
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("out_valid", k, ov[k], dv[k]);
            if (dv[k]) begin
                chk("out_zero", k, oz[k], dz[k]);
                chk("out_neg",  k, on[k], dn[k]);
            end
            chk("flag_z", k, fz[k], efz[k]);
            chk("flag_n", k, fn[k], efn[k]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 64'd0, 0, 0);
    endtask

    initial begin
        logic [63:0] r;
        in_valid = 0; in_set_flags = 0; flush = 0;
        data_a = '0; data_b = '0; data_c = '0;
        model_reset();

        reset = 1'b1;
        #1 reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_state();
        #5 reset = 1'b1;

        // Zero / negative detection with trailing flags
        step(1, 64'h0, 1, 0);
        step(1, 64'h1, 1, 0);
        step(1, 64'h8000_0000_0000_0000, 1, 0);
        step(1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        idle(6);

        // Flag gating: a non-setter must leave Z from the prior setter
        step(1, 64'h0, 1, 0);
        step(1, 64'h5, 0, 0);
        idle(6);
        chk("gate_flag_z", 0, fz[0], 1'b1);

        // Flush two cycles after a setter
        step(1, 64'h8000_0000_0000_0000, 1, 0);
        idle(5);
        step(1, 64'h0, 1, 0);
        idle(1);
        step(0, 64'h0, 0, 1);
        idle(5);
        chk("flush_flag_z", 0, fz[0], 1'b0);
        chk("flush_flag_n", 0, fn[0], 1'b1);

        // Walking one across every bit, then all-zero
        for (int i = 0; i < 64; i++) begin
            r = 64'd1 << i;
            step(1, r, 1, 0);
        end
        step(1, 64'h0, 1, 0);
        idle(6);

        // Reset mid-stream with entries in flight
        step(1, 64'h3, 1, 0);
        step(1, 64'h0, 1, 0);
        step(1, 64'h8000_0000_0000_0001, 1, 0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            chk("midrst_valid", k, ov[k], 1'b0);
            chk("midrst_flagz", k, fz[k], 1'b0);
            chk("midrst_flagn", k, fn[k], 1'b0);
        end
        #2 reset = 1'b1;
        step(1, 64'h0, 1, 0);
        idle(5);
        chk("post_rst_flag_z", 0, fz[0], 1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(3, 0))
                0:       r = 64'd0;
                1:       r = 64'd1 << $urandom_range(63, 0);
                2:       r = {$urandom, $urandom};
                default: r = {1'b1, 31'($urandom), 32'($urandom)};
            endcase
            step($urandom_range(3, 0) != 0, r, $urandom_range(1, 0) == 1,
                 $urandom_range(15, 0) == 0);
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
